// File: rtl/eth_pktbuf_ctrl.sv
// Circular packet-buffer controller around a ram2port: speculative frame writes with rollback and a
// 4-entry skid FIFO hiding the 2-cycle read latency. Drop statistics enabled by ETH_PKTBUF_STATS_EN.
`timescale 1ns/1ps
module eth_pktbuf_ctrl #(
  parameter int pWIDTH_DATA = 8,
  parameter int pWIDTH_ADDR = 11
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  input  logic                   wr_sof,
  input  logic                   wr_eof,
  input  logic                   wr_err,
  input  logic [pWIDTH_DATA-1:0] wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [pWIDTH_DATA-1:0] rd_data,
  output logic                   rd_eof,
  output logic [pWIDTH_ADDR:0]   rd_frames,
  output logic [15:0]            drop_cnt,
  output logic                   ram_clkena_a,
  output logic                   ram_clkena_b,
  output logic [pWIDTH_ADDR-1:0] ram_addr_a,
  output logic                   ram_wrena_a,
  output logic [pWIDTH_DATA:0]   ram_idata_a,
  output logic [pWIDTH_ADDR-1:0] ram_addr_b,
  output logic                   ram_wrena_b,
  input  logic [pWIDTH_DATA:0]   ram_odata_b
);
  localparam logic [pWIDTH_ADDR-1:0] lADDR_ZERO   = {pWIDTH_ADDR{1'b0}};
  localparam logic [pWIDTH_ADDR-1:0] lADDR_ONE    = {{(pWIDTH_ADDR-1){1'b0}}, 1'b1};
  localparam logic [pWIDTH_ADDR:0]   lFRAMES_ZERO = {(pWIDTH_ADDR+1){1'b0}};
  localparam logic [pWIDTH_ADDR:0]   lFRAMES_ONE  = {{pWIDTH_ADDR{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} wr_state_t;

  wr_state_t              state;
  logic [pWIDTH_ADDR-1:0] wr_commit, wr_cur, rd_issue, rd_pop;
  logic [pWIDTH_ADDR-1:0] commit_nxt, wr_base, beat_addr, next_addr;
  logic                   commit_pend, restart, accept, full;
  logic [1:0]             inflight;
  logic [pWIDTH_DATA:0]   skid [0:3];
  logic [1:0]             skid_wp, skid_rp;
  logic [2:0]             skid_cnt, outstanding;
  logic                   issue, push, pop;

  assign ram_clkena_a = 1'b1;
  assign ram_clkena_b = 1'b1;
  assign ram_wrena_b  = 1'b0;

  // A commit lands in wr_commit one cycle late, so a frame started right behind it must see the pending value
  assign wr_base   = commit_pend ? commit_nxt : wr_commit;
  assign restart   = wr_valid & wr_sof & ((state == IDLE) | (state == RECV));
  assign accept    = restart | (wr_valid & (state == RECV));
  assign beat_addr = restart ? wr_base : wr_cur;
  assign next_addr = beat_addr + lADDR_ONE;
  assign full      = (next_addr == rd_pop);

  assign outstanding = {2'b00, inflight[0]} + {2'b00, inflight[1]} + skid_cnt;
  assign issue       = (rd_issue != wr_commit) & (outstanding < 3'd4);
  assign push        = inflight[1];
  assign rd_valid    = (skid_cnt != 3'd0);
  assign pop         = rd_valid & rd_ready;
  assign {rd_eof, rd_data} = skid[skid_rp];
  assign ram_addr_b  = rd_issue;

  // Write FSM: RAM port A, speculative pointer and delayed commit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_cur      <= lADDR_ZERO;
      wr_commit   <= lADDR_ZERO;
      commit_nxt  <= lADDR_ZERO;
      commit_pend <= 1'b0;
      ram_wrena_a <= 1'b0;
      ram_addr_a  <= lADDR_ZERO;
      ram_idata_a <= {(pWIDTH_DATA+1){1'b0}};
    end else begin
      ram_wrena_a <= 1'b0;
      commit_pend <= 1'b0;
      if (commit_pend) wr_commit <= commit_nxt;
      case (state)
        IDLE, RECV: begin
          if (accept) begin
            if (full) begin
              wr_cur <= wr_base;
              state  <= wr_eof ? IDLE : DROP;
            end else begin
              ram_wrena_a <= 1'b1;
              ram_addr_a  <= beat_addr;
              ram_idata_a <= {wr_eof, wr_data};
              if (!wr_eof) begin
                wr_cur <= next_addr;
                state  <= RECV;
              end else if (wr_err) begin
                wr_cur <= wr_base;
                state  <= IDLE;
              end else begin
                wr_cur      <= next_addr;
                commit_nxt  <= next_addr;
                commit_pend <= 1'b1;
                state       <= IDLE;
              end
            end
          end
        end
        DROP: begin
          if (wr_valid && wr_eof) begin
            wr_cur <= wr_base;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read issue window, skid FIFO and committed-frame count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_issue  <= lADDR_ZERO;
      rd_pop    <= lADDR_ZERO;
      inflight  <= 2'b00;
      skid_wp   <= 2'd0;
      skid_rp   <= 2'd0;
      skid_cnt  <= 3'd0;
      rd_frames <= lFRAMES_ZERO;
      for (int i = 0; i < 4; i++) skid[i] <= {(pWIDTH_DATA+1){1'b0}};
    end else begin
      inflight <= {inflight[0], issue};
      if (issue) rd_issue <= rd_issue + lADDR_ONE;
      if (push) begin
        skid[skid_wp] <= ram_odata_b;
        skid_wp       <= skid_wp + 2'd1;
      end
      if (pop) begin
        skid_rp <= skid_rp + 2'd1;
        rd_pop  <= rd_pop + lADDR_ONE;
      end
      skid_cnt <= skid_cnt + {2'b00, push} - {2'b00, pop};
      if (commit_pend && !(pop && rd_eof)) rd_frames <= rd_frames + lFRAMES_ONE;
      else if (!commit_pend && pop && rd_eof) rd_frames <= rd_frames - lFRAMES_ONE;
    end
  end

`ifdef ETH_PKTBUF_STATS_EN
  logic        abort, drop_end;
  logic [16:0] drop_sum;

  // A new sof in RECV drops the partial frame; an errored, overflowing or DROP-state eof drops the current one
  assign abort    = wr_valid & wr_sof & (state == RECV);
  assign drop_end = (accept & wr_eof & (full | wr_err)) | (wr_valid & wr_eof & (state == DROP));
  assign drop_sum = {1'b0, drop_cnt} + {16'd0, abort} + {16'd0, drop_end};

  // Saturating dropped-frame counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) drop_cnt <= 16'd0;
    else          drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`else
  assign drop_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_eth_pktbuf_ctrl.sv
// Scoreboard bench for eth_pktbuf_ctrl: a large instance and a 16-word instance, each with a ram2port model.
`timescale 1ns/1ps
module tb_eth_pktbuf_ctrl;
`ifdef ETH_PKTBUF_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0, wr_sof = 1'b0, wr_eof = 1'b0, wr_err = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       rd_ready = 1'b0;
  logic       sel_small = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];
  logic [8:0] mon_exp;

  logic        b_wr_valid, b_rd_ready, b_rd_valid, b_rd_eof, b_cka, b_ckb, b_wrena_a, b_wrena_b;
  logic [7:0]  b_rd_data;
  logic [11:0] b_rd_frames;
  logic [15:0] b_drop;
  logic [10:0] b_addr_a, b_addr_b, b_addr_q;
  logic [8:0]  b_idata_a, b_odata_b;
  logic [8:0]  b_mem [0:2047];

  logic        s_wr_valid, s_rd_ready, s_rd_valid, s_rd_eof, s_cka, s_ckb, s_wrena_a, s_wrena_b;
  logic [7:0]  s_rd_data;
  logic [4:0]  s_rd_frames;
  logic [15:0] s_drop;
  logic [3:0]  s_addr_a, s_addr_b, s_addr_q;
  logic [8:0]  s_idata_a, s_odata_b;
  logic [8:0]  s_mem [0:15];

  assign b_wr_valid = wr_valid & ~sel_small;
  assign b_rd_ready = rd_ready & ~sel_small;
  assign s_wr_valid = wr_valid & sel_small;
  assign s_rd_ready = rd_ready & sel_small;

  eth_pktbuf_ctrl #(.pWIDTH_DATA(8), .pWIDTH_ADDR(11)) u_big (
    .clock(clock), .reset_n(reset_n), .wr_valid(b_wr_valid), .wr_sof(wr_sof), .wr_eof(wr_eof),
    .wr_err(wr_err), .wr_data(wr_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
    .rd_data(b_rd_data), .rd_eof(b_rd_eof), .rd_frames(b_rd_frames), .drop_cnt(b_drop),
    .ram_clkena_a(b_cka), .ram_clkena_b(b_ckb), .ram_addr_a(b_addr_a), .ram_wrena_a(b_wrena_a),
    .ram_idata_a(b_idata_a), .ram_addr_b(b_addr_b), .ram_wrena_b(b_wrena_b), .ram_odata_b(b_odata_b));

  eth_pktbuf_ctrl #(.pWIDTH_DATA(8), .pWIDTH_ADDR(4)) u_small (
    .clock(clock), .reset_n(reset_n), .wr_valid(s_wr_valid), .wr_sof(wr_sof), .wr_eof(wr_eof),
    .wr_err(wr_err), .wr_data(wr_data), .rd_valid(s_rd_valid), .rd_ready(s_rd_ready),
    .rd_data(s_rd_data), .rd_eof(s_rd_eof), .rd_frames(s_rd_frames), .drop_cnt(s_drop),
    .ram_clkena_a(s_cka), .ram_clkena_b(s_ckb), .ram_addr_a(s_addr_a), .ram_wrena_a(s_wrena_a),
    .ram_idata_a(s_idata_a), .ram_addr_b(s_addr_b), .ram_wrena_b(s_wrena_b), .ram_odata_b(s_odata_b));

  initial forever #5 clock = ~clock;

  // ram2port models: registered read address and registered output, old data on read-during-write
  always @(posedge clock) begin
    if (b_wrena_a) b_mem[b_addr_a] <= b_idata_a;
    b_addr_q  <= b_addr_b;
    b_odata_b <= b_mem[b_addr_q];
    if (s_wrena_a) s_mem[s_addr_a] <= s_idata_a;
    s_addr_q  <= s_addr_b;
    s_odata_b <= s_mem[s_addr_q];
  end

  logic        cur_valid, cur_eof, cur_wrena_a;
  logic [7:0]  cur_data;
  logic [11:0] cur_frames;
  logic [15:0] cur_drop;
  logic [10:0] cur_addr_a;
  assign cur_valid   = sel_small ? s_rd_valid : b_rd_valid;
  assign cur_eof     = sel_small ? s_rd_eof : b_rd_eof;
  assign cur_data    = sel_small ? s_rd_data : b_rd_data;
  assign cur_frames  = sel_small ? {7'd0, s_rd_frames} : b_rd_frames;
  assign cur_drop    = sel_small ? s_drop : b_drop;
  assign cur_addr_a  = sel_small ? {7'd0, s_addr_a} : b_addr_a;
  assign cur_wrena_a = sel_small ? s_wrena_a : b_wrena_a;

  // Scoreboard: every accepted output beat is compared with the oldest expected {eof, data}
  always @(negedge clock) begin
    if (reset_n && cur_valid && rd_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got eof=%0b data=%02h required no beat", cur_eof, cur_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({cur_eof, cur_data} !== mon_exp) begin
          errors++;
          $display("FAIL beat got eof=%0b data=%02h required eof=%0b data=%02h",
                   cur_eof, cur_data, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    wr_valid = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0; wr_err = 1'b0;
    sb.delete();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic drive_frame(input int len, input int base, input bit err, input bit do_eof,
                             input bit expect_out, output logic [10:0] first_addr);
    first_addr = 11'd0;
    for (int i = 0; i < len; i++) begin
      wr_valid = 1'b1;
      wr_sof   = (i == 0);
      wr_eof   = do_eof && (i == len - 1);
      wr_err   = err && do_eof && (i == len - 1);
      wr_data  = 8'(base + i);
      if (expect_out) sb.push_back({wr_eof, wr_data});
      @(posedge clock); #1;
      if (i == 0) first_addr = cur_addr_a;
    end
    wr_valid = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0; wr_err = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b required 0", b_rd_valid); end
    checks++; if (b_rd_frames !== 12'd0) begin errors++; $display("FAIL reset_rd_frames got %0d required 0", b_rd_frames); end
    checks++; if (b_drop !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d required 0", b_drop); end
    checks++; if (b_wrena_a !== 1'b0) begin errors++; $display("FAIL reset_wrena_a got %0b required 0", b_wrena_a); end
    checks++; if (b_addr_b !== 11'd0) begin errors++; $display("FAIL reset_addr_b got %0d required 0", b_addr_b); end
    checks++; if ({b_cka, b_ckb, b_wrena_b} !== 3'b110) begin errors++; $display("FAIL ram_constants got %b required 110", {b_cka, b_ckb, b_wrena_b}); end
    checks++; if ({s_rd_valid, s_rd_frames} !== 6'd0) begin errors++; $display("FAIL reset_small got %b required 0", {s_rd_valid, s_rd_frames}); end
  endtask

  task automatic test_good64();
    logic [10:0] fa;
    int lat, nvalid;
    do_reset();
    rd_ready = 1'b1;
    drive_frame(64, 0, 1'b0, 1'b1, 1'b1, fa);
    lat = 1;
    while (!cur_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++; if (lat != 5) begin errors++; $display("FAIL eof_to_valid_latency got %0d required 5", lat); end
    checks++; if (cur_frames !== 12'd1) begin errors++; $display("FAIL frames_during_read got %0d required 1", cur_frames); end
    nvalid = 0;
    repeat (64) begin
      if (cur_valid) nvalid++;
      @(posedge clock); #1;
    end
    checks++; if (nvalid != 64) begin errors++; $display("FAIL consecutive_beats got %0d required 64", nvalid); end
    checks++; if (cur_frames !== 12'd0) begin errors++; $display("FAIL frames_after_read got %0d required 0", cur_frames); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL good64_leftover got %0d required 0", sb.size()); end
  endtask

  task automatic test_err_frame();
    logic [10:0] fa;
    do_reset();
    rd_ready = 1'b1;
    drive_frame(10, 8'h40, 1'b1, 1'b1, 1'b0, fa);
    drive_frame(4, 8'h80, 1'b0, 1'b1, 1'b1, fa);
    checks++; if (fa !== 11'd0) begin errors++; $display("FAIL good_after_err_addr got %0d required 0", fa); end
    wait_drain(40);
    repeat (10) begin @(posedge clock); #1; end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL err_frame_leftover got %0d required 0", sb.size()); end
    checks++; if (cur_drop !== 16'(STATS)) begin errors++; $display("FAIL err_drop_cnt got %0d required %0d", cur_drop, STATS); end
  endtask

  task automatic test_overflow();
    logic [10:0] fa;
    do_reset();
    sel_small = 1'b1;
    rd_ready = 1'b0;
    drive_frame(20, 0, 1'b0, 1'b1, 1'b0, fa);
    repeat (8) begin @(posedge clock); #1; end
    checks++; if ({cur_valid, cur_frames} !== 13'd0) begin errors++; $display("FAIL overflow_readable got valid=%0b frames=%0d required 0", cur_valid, cur_frames); end
    checks++; if (cur_drop !== 16'(STATS)) begin errors++; $display("FAIL overflow_drop_cnt got %0d required %0d", cur_drop, STATS); end
    drive_frame(15, 8'h20, 1'b0, 1'b1, 1'b1, fa);
    repeat (8) begin @(posedge clock); #1; end
    checks++; if ({cur_valid, cur_frames} !== {1'b1, 12'd1}) begin errors++; $display("FAIL fill15_commit got valid=%0b frames=%0d required valid=1 frames=1", cur_valid, cur_frames); end
    drive_frame(1, 8'hEE, 1'b0, 1'b1, 1'b0, fa);
    repeat (4) begin @(posedge clock); #1; end
    checks++; if (cur_drop !== 16'(2 * STATS)) begin errors++; $display("FAIL full_buffer_drop got %0d required %0d", cur_drop, 2 * STATS); end
    checks++; if (cur_frames !== 12'd1) begin errors++; $display("FAIL full_buffer_frames got %0d required 1", cur_frames); end
    rd_ready = 1'b1;
    wait_drain(60);
    repeat (5) begin @(posedge clock); #1; end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fill15_leftover got %0d required 0", sb.size()); end
    checks++; if (cur_frames !== 12'd0) begin errors++; $display("FAIL fill15_frames_end got %0d required 0", cur_frames); end
    rd_ready = 1'b0;
    sel_small = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [10:0] fa;
    logic [11:0] peak;
    do_reset();
    rd_ready = 1'b0;
    peak = 12'd0;
    fork
      begin
        drive_frame(5, 8'h10, 1'b0, 1'b1, 1'b1, fa);
        drive_frame(5, 8'h20, 1'b0, 1'b1, 1'b1, fa);
        drive_frame(5, 8'h30, 1'b0, 1'b1, 1'b1, fa);
      end
      begin
        repeat (70) begin
          @(posedge clock); #1;
          rd_ready = ~rd_ready;
          if (cur_frames > peak) peak = cur_frames;
        end
      end
    join
    rd_ready = 1'b1;
    wait_drain(40);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d required 0", sb.size()); end
    checks++; if (peak !== 12'd3) begin errors++; $display("FAIL b2b_frames_peak got %0d required 3", peak); end
    checks++; if (cur_frames !== 12'd0) begin errors++; $display("FAIL b2b_frames_end got %0d required 0", cur_frames); end
  endtask

  task automatic test_missing_eof();
    logic [10:0] fa;
    do_reset();
    rd_ready = 1'b1;
    drive_frame(7, 8'h60, 1'b0, 1'b0, 1'b0, fa);
    drive_frame(3, 8'h70, 1'b0, 1'b1, 1'b1, fa);
    checks++; if (fa !== 11'd0) begin errors++; $display("FAIL restart_addr got %0d required 0", fa); end
    wait_drain(40);
    repeat (10) begin @(posedge clock); #1; end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL missing_eof_leftover got %0d required 0", sb.size()); end
    checks++; if (cur_drop !== 16'(STATS)) begin errors++; $display("FAIL missing_eof_drop got %0d required %0d", cur_drop, STATS); end
  endtask

  task automatic test_reset_midread();
    logic [10:0] fa;
    int lat, nstale;
    do_reset();
    rd_ready = 1'b0;
    drive_frame(8, 8'h90, 1'b0, 1'b1, 1'b1, fa);
    lat = 1;
    while (!cur_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++; if (lat != 5) begin errors++; $display("FAIL stalled_latency got %0d required 5", lat); end
    reset_n = 1'b0;
    #1;
    checks++; if ({cur_valid, cur_frames} !== 13'd0) begin errors++; $display("FAIL async_reset_rd got valid=%0b frames=%0d required 0", cur_valid, cur_frames); end
    checks++; if ({cur_wrena_a, cur_addr_a, b_addr_b} !== 23'd0) begin errors++; $display("FAIL async_reset_ram got %0h required 0", {cur_wrena_a, cur_addr_a, b_addr_b}); end
    sb.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    rd_ready = 1'b1;
    nstale = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (cur_valid) nstale++;
    end
    checks++; if (nstale != 0) begin errors++; $display("FAIL stale_after_reset got %0d required 0", nstale); end
  endtask

  initial begin
    test_reset();
    test_good64();
    test_err_frame();
    test_overflow();
    test_back_to_back();
    test_missing_eof();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_pktbuf_ctrl.md
# eth_pktbuf_ctrl

Single-clock frame buffer controller that sequences one dual-port RAM (the EthCore `ram2port`: port A write, port B read, registered address and output) as a circular packet store between the RX MAC byte stream and a back-pressured consumer. Frames are written speculatively and become readable only after a clean end-of-frame. Errored or overflowing frames are rolled back without consuming space. On the read side the controller hides the RAM's 2-cycle read latency behind a 4-entry skid FIFO.

## Interface
Parameters:
- pWIDTH_DATA, 8: payload width; RAM word is pWIDTH_DATA+1 bits ({last, data}).
- pWIDTH_ADDR, 11: RAM address width; depth D = 2**pWIDTH_ADDR, usable capacity D-1 words.

Ports:
- clock  in  1  single clock for controller and both RAM ports.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  input beat valid; no back-pressure, the MAC cannot stall.
- wr_sof  in  1  first beat of a frame.
- wr_eof  in  1  last beat of a frame.
- wr_err  in  1  qualifies wr_eof; frame is bad and must be dropped.
- wr_data  in  pWIDTH_DATA  input byte.
- rd_valid  out  1  output beat valid.
- rd_ready  in  1  consumer accepts the beat.
- rd_data  out  pWIDTH_DATA  output byte.
- rd_eof  out  1  last beat of a frame.
- rd_frames  out  pWIDTH_ADDR+1  number of committed frames not yet fully popped.
- drop_cnt  out  16  dropped-frame counter (see Configuration).
- ram_clkena_a, ram_clkena_b  out  1  constant 1.
- ram_addr_a  out  pWIDTH_ADDR  write address, registered.
- ram_wrena_a  out  1  write enable, registered.
- ram_idata_a  out  pWIDTH_DATA+1  write word {eof, data}, registered.
- ram_addr_b  out  pWIDTH_ADDR  read address, driven combinationally from rd_issue.
- ram_wrena_b  out  1  constant 0.
- ram_odata_b  in  pWIDTH_DATA+1  read word, valid 2 cycles after its address.

## Operation
- Pointers, each pWIDTH_ADDR bits, wrapping modulo D: wr_commit, wr_cur (speculative), rd_issue, rd_pop. All reset to 0.
- Write FSM states and transitions:
  - IDLE: wr_valid&wr_sof sets wr_cur to wr_commit, writes the beat, and moves to RECV (or commits immediately if wr_eof on the same beat).
  - RECV: each wr_valid beat writes at wr_cur, then wr_cur++.
  - DROP: beats are ignored until eof.
- Full condition: wr_cur+1 == rd_pop. A beat arriving while full goes to DROP and is not written.
- End of frame:
  - wr_eof & !wr_err in RECV: the beat is written with last=1, wr_commit becomes wr_cur+1, rd_frames++, state goes to IDLE.
  - wr_eof with wr_err, or any eof in DROP: wr_cur returns to wr_commit, drop is counted, state goes to IDLE.
- wr_sof in RECV (missing eof): the partial frame is dropped and counted, and the new frame restarts at wr_commit.
- Beats in IDLE without wr_sof are ignored.
- Read issue: the controller issues a read when rd_issue != wr_commit and (in-flight + skid occupancy) < 4, then rd_issue++. The in-flight window is a 2-bit valid shift register.
- Returned words are pushed into the skid FIFO. rd_valid = skid not empty.
- Pop on rd_valid&rd_ready advances rd_pop. If the popped word has last=1, rd_frames--.
- Simultaneous rd_frames++ and rd_frames-- leave rd_frames unchanged.
- Reads never stop at frame boundaries; consecutive committed frames stream back-to-back.

## Timing
- Reset values: all pointers 0, FSM in IDLE, rd_valid 0, rd_frames 0, drop_cnt 0, ram_wrena_a 0, skid FIFO and in-flight register empty.
- Reset mid-frame or mid-read discards all buffered and in-flight data.
- Write path: a beat at cycle N appears on RAM port A in cycle N+1. A commit at eof cycle N makes wr_commit visible at N+2.
- The earliest read of a word is issued at N+2, after its write cycle, because mixed-port read-during-write returns old data.
- Read path: issue at T, ram_odata_b valid at T+2, skid push at the end of T+2, rd_valid at T+3.
- End-to-end, from single-beat frame at N to rd_valid: N+5.
- With rd_ready held high, throughput is 1 beat per clock.
- With rd_ready low, issue stops once 4 words are outstanding. The skid FIFO never overflows and no data is lost.

## Configuration
- ETH_PKTBUF_STATS_EN defined: drop_cnt increments by 1 per dropped frame (error, overflow, or missing eof) and saturates at 16'hFFFF.
- ETH_PKTBUF_STATS_EN undefined: the counter logic is removed and drop_cnt is tied to 0. Buffer behaviour is otherwise identical.

## Test plan
- Reset, then a 64-byte good frame of bytes 0..63 with rd_ready=1:
  - rd_valid first rises 5 cycles after the frame's eof beat.
  - 64 consecutive beats arrive, rd_eof is set on byte 63, and rd_frames goes 1→0.
- A 10-byte frame with wr_err on eof, followed by a 4-byte good frame:
  - Only the 4-byte frame is output.
  - The 4-byte frame starts at address 0.
  - drop_cnt=1 with the macro, 0 without.
- pWIDTH_ADDR=4 (capacity 15), consumer stalled, a 20-byte frame:
  - The frame is dropped and nothing is readable.
  - A following 15-byte frame is accepted, filling the buffer exactly.
- Three 5-byte frames back-to-back with rd_ready toggling 1/0 every cycle:
  - All 15 bytes arrive in order with rd_eof on bytes 5, 10 and 15.
  - No beat is duplicated or lost.
  - rd_frames peaks at 3.
- wr_sof mid-frame after 7 bytes, then a good 3-byte frame:
  - The 7 bytes are discarded, the 3-byte frame is output, and drop_cnt increments.
- reset_n asserted while 2 reads are in flight and rd_valid=1:
  - All outputs return to reset values immediately.
  - No stale beat appears after release.
